uart_rx: RTL

- UART receiver; the downstream counterpart of the UART transmitter.
- Samples a serial line, recovers 8N1 or 8N2 frames (start bit, LSB-first data, stop bits) and presents each byte on a valid/ready output holding register.
- Sits between the board RX pin (or the loopback from the TX stage) and the byte consumer.
- Reports frame errors and overruns as single-cycle pulses.

---
 rtl/uart_rx_if.sv | 24 ++
 rtl/uart_rx.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/uart_rx_if.sv
// Byte-stream handshake between the UART receiver and its consumer.
//   data_out   : received byte, stable while data_valid is high and not accepted
//   data_valid : a byte is waiting in the holding register
//   data_ready : consumer takes the byte on a cycle where data_valid && data_ready
// master = receiver side, slave = consumer side.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_valid;
  logic                  data_ready;

  modport master (
    output data_out,
    output data_valid,
    input  data_ready
  );

  modport slave (
    input  data_out,
    input  data_valid,
    output data_ready
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver for 8N1/8N2 frames. Synchronises the serial line, finds the
// start bit, samples each data bit mid-cell (LSB first), checks the first stop
// bit and hands the byte to a single-entry valid/ready holding register.
// Ports:
//   clk, rst   : rising-edge clock, synchronous active-high reset
//   rx         : asynchronous serial input, idles high
//   bus        : byte handshake (data_out / data_valid / data_ready)
//   busy       : a frame is in progress (START, DATA or STOP)
//   frame_err  : one-cycle pulse, first stop bit sampled low
//   overrun    : one-cycle pulse, good frame arrived while a byte was still held
module uart_rx #(
  parameter int DATA_WIDTH = 8,
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD_RATE  = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  uart_rx_if.master  bus,
  output logic       busy,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = $clog2(CLKS_PER_BIT);
  localparam int BIT_W        = $clog2(DATA_WIDTH + 1);

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    S_WAIT_IDLE,
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  state_t                state_q, state_d;
  logic                  rx_m, rx_s;
  logic                  armed_q;
  logic [CNT_W-1:0]      baud_q, baud_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic                  ferr_q, ferr_d;
  logic                  ovr_q, ovr_d;

  // NOTE: every register here is written with <= so all flops update from
  // the same pre-edge values; blocking writes would make results order-dependent.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      armed_q <= 1'b0;
      state_q <= S_WAIT_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      rx_m    <= rx;
      rx_s    <= rx_m;
      armed_q <= 1'b1;
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    if (valid_q && bus.data_ready) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      // Both synchroniser flops still hold their reset value of 1 right after
      // reset; armed_q and rx_m make sure a line that was held low through
      // reset is seen low before the receiver is allowed to arm.
      S_WAIT_IDLE: begin
        if (armed_q && rx_m && rx_s) begin
          state_d = S_IDLE;
        end
      end

      S_IDLE: begin
        if (!rx_s) begin
          state_d = S_START;
          baud_d  = '0;
        end
      end

      // Half a bit in, the start bit must still be low or it was a glitch.
      S_START: begin
        if (baud_q == HALF_LAST) begin
          baud_d = '0;
          if (rx_s) begin
            state_d = S_IDLE;
          end else begin
            state_d = S_DATA;
            bit_d   = '0;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end

      // Shifting in from the top leaves the first (LSB) bit at position 0
      // once all DATA_WIDTH bits are in.
      S_DATA: begin
        if (baud_q == BIT_LAST) begin
          baud_d  = '0;
          shift_d = {rx_s, shift_q[DATA_WIDTH-1:1]};
          bit_d   = bit_q + BIT_W'(1);
          if (bit_q == DATA_LAST) begin
            state_d = S_STOP;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end

      // Only the first stop bit is checked; a second one is simply idle line.
      S_STOP: begin
        if (baud_q == BIT_LAST) begin
          baud_d = '0;
          if (rx_s) begin
            state_d = S_IDLE;
            if (!valid_q || bus.data_ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d  = 1'b1;
            state_d = S_WAIT_IDLE;
          end
        end else begin
          baud_d = baud_q + CNT_W'(1);
        end
      end

      default: state_d = S_WAIT_IDLE;
    endcase
  end

  assign busy           = (state_q == S_START) || (state_q == S_DATA) || (state_q == S_STOP);
  assign frame_err      = ferr_q;
  assign overrun        = ovr_q;
  assign bus.data_out   = data_q;
  assign bus.data_valid = valid_q;

endmodule
